// File: rtl/pci_bus_arbiter_if.sv
// Shared frame/irdy bus bundle between the arbiter/sequencer and the requesters/target.
interface pci_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LEN_W   = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic                     trdy;
    logic [NUM_REQ-1:0]       gnt;
    logic                     frame;
    logic                     irdy;
    logic [1:0]               bus_state;
    logic                     done;
    logic                     err;

    modport master (
        input  req, req_len, trdy,
        output gnt, frame, irdy, bus_state, done, err
    );

    modport slave (
        output req, req_len, trdy,
        input  gnt, frame, irdy, bus_state, done, err
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Round-robin arbiter plus frame/irdy burst sequencer with per-beat trdy timeout.
module pci_bus_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    pci_bus_arbiter_if.master   bus
);
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [1:0]  BUS_IDLE = 2'b01;
    localparam logic [1:0]  BUS_BUSY = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_TURN} state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [LEN_W-1:0]    r_remain;
    logic [WAIT_W-1:0]   r_wait;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_frame;
    logic                r_irdy;
    logic [1:0]          r_bus_state;
    logic                r_done;
    logic                r_err;

    logic                w_any;
    logic [PTR_W-1:0]    w_cand;
    logic [PTR_W-1:0]    w_win;
    logic [PTR_W-1:0]    w_ptr_nxt;
    logic [LEN_W-1:0]    w_len;
    logic [LEN_W-1:0]    w_len_eff;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return PTR_W'(sum);
    endfunction

    // Scan from the farthest offset down so the nearest request at/after r_ptr wins.
    always_comb begin
        w_any  = |bus.req;
        w_win  = '0;
        w_cand = '0;
        w_len  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = wrap_idx(r_ptr, NUM_REQ - 1 - k);
            if (bus.req[w_cand]) w_win = w_cand;
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (PTR_W'(k) == w_win) w_len = bus.req_len[k*LEN_W +: LEN_W];
        end
        w_len_eff = (w_len == '0) ? LEN_W'(1) : w_len;
        w_ptr_nxt = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_remain    <= '0;
            r_wait      <= '0;
            r_gnt       <= '0;
            r_frame     <= 1'b0;
            r_irdy      <= 1'b0;
            r_bus_state <= BUS_IDLE;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state     <= S_ADDR;
                        r_gnt       <= NUM_REQ'(1) << w_win;
                        r_ptr       <= w_ptr_nxt;
                        r_remain    <= w_len_eff;
                        r_wait      <= '0;
                        r_frame     <= 1'b1;
                        r_irdy      <= 1'b0;
                        r_bus_state <= BUS_BUSY;
                    end
                end
                S_ADDR: begin
                    r_state <= S_DATA;
                    r_irdy  <= 1'b1;
                    r_frame <= (r_remain > LEN_W'(1));
                end
                S_DATA: begin
                    if (bus.trdy) begin
                        r_wait   <= '0;
                        r_remain <= r_remain - LEN_W'(1);
                        if (r_remain == LEN_W'(1)) begin
                            r_state <= S_TURN;
                            r_frame <= 1'b0;
                            r_irdy  <= 1'b0;
                            r_gnt   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_frame <= (r_remain > LEN_W'(2));
                        end
                    end else if (r_wait == WAIT_W'(MAX_WAIT - 1)) begin
                        // This stalled cycle is the MAX_WAIT-th in a row: abort.
                        r_state <= S_TURN;
                        r_frame <= 1'b0;
                        r_irdy  <= 1'b0;
                        r_gnt   <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_TURN: begin
                    r_state     <= S_IDLE;
                    r_bus_state <= BUS_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.frame     = r_frame;
    assign bus.irdy      = r_irdy;
    assign bus.bus_state = r_bus_state;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
- Round-robin arbiter and master sequencer for the shared frame/irdy bus.
- Grants one of NUM_REQ requesters and drives frame and irdy through address, data, last-data and turnaround phases.
- Counts data beats against the target's trdy and publishes bus_state (BUSIDLE/BUSBUSY) for the bus-protocol assertions.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- LEN_W, 4, width of each requester's burst-length field
- MAX_WAIT, 16, max cycles waiting for trdy on one beat before abort

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  NUM_REQ  request vector, bit i = requester i
- req_len  input  NUM_REQ*LEN_W  burst length in beats, requester i at bits [i*LEN_W +: LEN_W]
- trdy  input  1  target ready; a beat completes on irdy && trdy
- gnt  output  NUM_REQ  one-hot grant, registered
- frame  output  1  transaction framing, registered
- irdy  output  1  initiator ready, registered
- bus_state  output  2  2'b01 = BUSIDLE, 2'b10 = BUSBUSY
- done  output  1  one-cycle pulse, burst completed normally
- err  output  1  one-cycle pulse, burst aborted on timeout

Behaviour:
- Reset (rst_n low at posedge):
  - State goes to IDLE; gnt, frame, irdy, done and err are 0; bus_state is 2'b01.
  - Priority pointer = 0; beat and wait counters = 0.
  - Reset mid-burst aborts immediately with no done/err pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, ADDR, DATA, TURN.
- IDLE:
  - frame = irdy = 0, gnt = 0, bus_state = 01.
  - If req != 0, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch that requester's req_len; length 0 is treated as 1.
  - Next cycle: gnt one-hot, state ADDR.
  - Pointer becomes winner+1, modulo NUM_REQ.
- ADDR (exactly 1 cycle): frame = 1, irdy = 0, bus_state = 10; next state DATA.
- DATA:
  - irdy = 1; frame = 1 while remaining beats > 1; frame = 0 during the final beat.
  - On irdy && trdy: remaining decrements and the wait counter clears.
  - On the final beat's completion: next state TURN, done pulses in the TURN cycle.
  - Wait counter increments each DATA cycle with trdy low.
  - When the wait counter reaches MAX_WAIT: next state TURN, err pulses in the TURN cycle, done stays 0.
- TURN (exactly 1 cycle):
  - frame = irdy = 0, gnt = 0, bus_state = 10.
  - Next state IDLE; no back-to-back grant without a TURN cycle.
- bus_state = 10 in ADDR, DATA and TURN; 01 only in IDLE.
- Request changes after the grant are ignored; the burst always runs to completion or timeout.
- Simultaneous requests are resolved purely by the pointer.
- The same requester may win again if it is the only requester.
- done and err are never both high.
- frame is never high while gnt == 0.

Test Plan:
- Reset with req=4'b1111 held: all outputs 0 and bus_state=01 while rst_n=0; after release, gnt=4'b0001 one cycle later, frame=1 and irdy=0 in the ADDR cycle.
- req=4'b0100, len=3, trdy=1 constantly: gnt=0100, then ADDR 1 cycle, then DATA with frame=1,1,0 and irdy=1,1,1, then TURN, done=1 for 1 cycle, then IDLE with bus_state=01.
- req=4'b1111 held, all len=1: grants rotate 0001, 0010, 0100, 1000, 0001; each burst is exactly ADDR + 1 DATA + TURN.
- len=2, trdy low for 3 cycles on beat 1: irdy stays 1 and frame stays 1 through the waits; completes after 2 handshakes; done pulses.
- len=2, trdy held 0, MAX_WAIT=16: abort after 16 wait cycles; err=1 for one cycle; done=0; frame=irdy=0 in TURN; next grant proceeds normally.
- rst_n low for 1 cycle during DATA: next cycle all outputs 0, no done/err; next grant goes to the lowest-index active requester.
